// File: rtl/mor1kx_cfgrs_spr_port.sv
// rtl/mor1kx_cfgrs_spr_port.sv - SPR-bus slave for the group-0 read-only configuration registers
//
// Serves the eleven constant configuration words from the configuration-register
// generator on the SPR bus. The ack latency is fixed by a parameter. Write attempts
// are flagged, and a signature of the configuration words is checked continuously.
//
// Parameters:
//   OPTION_SPR_ACK_LATENCY  cycles from accepted strobe to ack (1..4, otherwise 1)
//   FEATURE_CFG_CHECK       "NONE" removes the signature logic
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   spr_vr .. spr_avr             32-bit configuration words (index 0..10)
//   spr_bus_addr_i                [15:11] group, [10:0] index
//   spr_bus_stb_i/we_i/dat_i      strobe (held until ack), write enable, write data (ignored)
//   spr_bus_dat_o/ack_o           read data (valid with ack), one-cycle ack pulse
//   ro_wr_err_o, ro_wr_cnt_o      sticky write-attempt flag, saturating write count
//   cfg_mismatch_o                sticky signature-check failure
//   cfg_clear_i                   synchronous clear of the sticky flags and counter

module mor1kx_cfgrs_spr_port #(
  parameter int    OPTION_SPR_ACK_LATENCY = 1,
  parameter string FEATURE_CFG_CHECK      = "ENABLED"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] spr_vr,
  input  logic [31:0] spr_vr2,
  input  logic [31:0] spr_upr,
  input  logic [31:0] spr_cpucfgr,
  input  logic [31:0] spr_dmmucfgr,
  input  logic [31:0] spr_immucfgr,
  input  logic [31:0] spr_dccfgr,
  input  logic [31:0] spr_iccfgr,
  input  logic [31:0] spr_dcfgr,
  input  logic [31:0] spr_pccfgr,
  input  logic [31:0] spr_avr,
  input  logic [15:0] spr_bus_addr_i,
  input  logic        spr_bus_stb_i,
  input  logic        spr_bus_we_i,
  input  logic [31:0] spr_bus_dat_i,
  output logic [31:0] spr_bus_dat_o,
  output logic        spr_bus_ack_o,
  output logic        ro_wr_err_o,
  output logic [7:0]  ro_wr_cnt_o,
  output logic        cfg_mismatch_o,
  input  logic        cfg_clear_i
);

  localparam int LAT = (OPTION_SPR_ACK_LATENCY >= 1 && OPTION_SPR_ACK_LATENCY <= 4) ?
                       OPTION_SPR_ACK_LATENCY : 1;
  localparam logic [1:0] CNT_INIT = 2'(LAT - 1);
  localparam bit CHECK_EN = (FEATURE_CFG_CHECK != "NONE");

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_HOLD
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [31:0] r_word;
  logic        r_wr_hit;

  logic [31:0] w_cfg [11];
  logic        w_grp0;
  logic        w_idx_hit;
  logic [31:0] w_rd_word;
  logic [31:0] w_acc_word;
  logic        w_accept;
  logic        w_wr_evt;
  logic        w_unused;

  // Write data is never stored; the reduction only marks it as intentionally unused.
  assign w_unused = ^spr_bus_dat_i;

  assign w_cfg[0]  = spr_vr;
  assign w_cfg[1]  = spr_upr;
  assign w_cfg[2]  = spr_cpucfgr;
  assign w_cfg[3]  = spr_dmmucfgr;
  assign w_cfg[4]  = spr_immucfgr;
  assign w_cfg[5]  = spr_dccfgr;
  assign w_cfg[6]  = spr_iccfgr;
  assign w_cfg[7]  = spr_dcfgr;
  assign w_cfg[8]  = spr_pccfgr;
  assign w_cfg[9]  = spr_vr2;
  assign w_cfg[10] = spr_avr;

  assign w_grp0    = (spr_bus_addr_i[15:11] == 5'd0);
  assign w_idx_hit = (spr_bus_addr_i[10:0] <= 11'd10);
  assign w_accept  = (r_state == ST_IDLE) && spr_bus_stb_i && w_grp0;

  always_comb begin
    w_rd_word = 32'd0;
    if (w_idx_hit) begin
      case (spr_bus_addr_i[3:0])
        4'd0:    w_rd_word = w_cfg[0];
        4'd1:    w_rd_word = w_cfg[1];
        4'd2:    w_rd_word = w_cfg[2];
        4'd3:    w_rd_word = w_cfg[3];
        4'd4:    w_rd_word = w_cfg[4];
        4'd5:    w_rd_word = w_cfg[5];
        4'd6:    w_rd_word = w_cfg[6];
        4'd7:    w_rd_word = w_cfg[7];
        4'd8:    w_rd_word = w_cfg[8];
        4'd9:    w_rd_word = w_cfg[9];
        4'd10:   w_rd_word = w_cfg[10];
        default: w_rd_word = 32'd0;
      endcase
    end
  end

  // Writes are answered with zero data.
  assign w_acc_word = spr_bus_we_i ? 32'd0 : w_rd_word;

  // A write-attempt event coincides with the edge that raises ack.
  assign w_wr_evt = (w_accept && (CNT_INIT == 2'd0) && spr_bus_we_i && w_idx_hit) ||
                    ((r_state == ST_WAIT) && (r_cnt == 2'd1) && r_wr_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_INIT;
      r_cnt         <= 2'd0;
      r_word        <= 32'd0;
      r_wr_hit      <= 1'b0;
      spr_bus_ack_o <= 1'b0;
      spr_bus_dat_o <= 32'd0;
    end else begin
      spr_bus_ack_o <= 1'b0;
      spr_bus_dat_o <= 32'd0;
      case (r_state)
        ST_INIT: r_state <= ST_IDLE;
        ST_IDLE: begin
          if (w_accept) begin
            r_word   <= w_acc_word;
            r_wr_hit <= spr_bus_we_i && w_idx_hit;
            if (CNT_INIT == 2'd0) begin
              r_state       <= ST_ACK;
              spr_bus_ack_o <= 1'b1;
              spr_bus_dat_o <= w_acc_word;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_state       <= ST_ACK;
            spr_bus_ack_o <= 1'b1;
            spr_bus_dat_o <= r_word;
          end
        end
        ST_ACK: r_state <= ST_HOLD;
        ST_HOLD: begin
          // The master must drop stb before a new access is accepted.
          if (!spr_bus_stb_i) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_wr_err_o <= 1'b0;
      ro_wr_cnt_o <= 8'd0;
    end else if (cfg_clear_i) begin
      ro_wr_err_o <= 1'b0;
      ro_wr_cnt_o <= 8'd0;
    end else if (w_wr_evt) begin
      ro_wr_err_o <= 1'b1;
      if (ro_wr_cnt_o != 8'hFF) ro_wr_cnt_o <= ro_wr_cnt_o + 8'd1;
    end
  end

  generate
    if (CHECK_EN) begin : g_check
      logic [31:0] w_sig;
      logic [31:0] r_sig;
      logic        r_mismatch;

      // XOR of word k rotated left by k; the upper half of {w,w}<<k is the rotation.
      always_comb begin
        logic [63:0] v_dbl;
        w_sig = 32'd0;
        for (int k = 0; k < 11; k++) begin
          v_dbl = {w_cfg[k], w_cfg[k]} << k;
          w_sig = w_sig ^ v_dbl[63:32];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sig      <= 32'd0;
          r_mismatch <= 1'b0;
        end else begin
          if (r_state == ST_INIT) r_sig <= w_sig;
          if (cfg_clear_i) r_mismatch <= 1'b0;
          else if ((r_state != ST_INIT) && (w_sig != r_sig)) r_mismatch <= 1'b1;
        end
      end

      assign cfg_mismatch_o = r_mismatch;
    end else begin : g_no_check
      assign cfg_mismatch_o = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_port.sv
// tb/tb_mor1kx_cfgrs_spr_port.sv - randomized self-checking bench for mor1kx_cfgrs_spr_port

module tb_mor1kx_cfgrs_spr_port;

  localparam int NDUT  = 5;
  localparam int HOLDC = 10;

  // Instances: 0 lat1, 1 lat3, 2 lat4, 3 lat7 (illegal -> 1), 4 lat2 without check.
  int lat_exp  [NDUT] = '{1, 3, 4, 1, 2};
  bit check_en [NDUT] = '{1, 1, 1, 1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cfg [11];
  logic [15:0] spr_bus_addr_i = 16'd0;
  logic        spr_bus_stb_i = 1'b0;
  logic        spr_bus_we_i = 1'b0;
  logic [31:0] spr_bus_dat_i = 32'd0;
  logic        cfg_clear_i = 1'b0;

  logic [31:0] dat_o [NDUT];
  logic        ack_o [NDUT];
  logic        err_o [NDUT];
  logic [7:0]  cnt_o [NDUT];
  logic        mm_o  [NDUT];

  int n_chk  = 0;
  int n_fail = 0;

  logic       m_err;
  logic [7:0] m_cnt;
  logic       m_mm [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mor1kx_cfgrs_spr_port #(
      .OPTION_SPR_ACK_LATENCY(g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 7),
      .FEATURE_CFG_CHECK("ENABLED")
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .spr_vr(cfg[0]), .spr_vr2(cfg[9]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]),
      .spr_dmmucfgr(cfg[3]), .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]),
      .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]), .spr_pccfgr(cfg[8]), .spr_avr(cfg[10]),
      .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
      .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
      .spr_bus_dat_o(dat_o[g]), .spr_bus_ack_o(ack_o[g]),
      .ro_wr_err_o(err_o[g]), .ro_wr_cnt_o(cnt_o[g]),
      .cfg_mismatch_o(mm_o[g]), .cfg_clear_i(cfg_clear_i)
    );
  end

  mor1kx_cfgrs_spr_port #(
    .OPTION_SPR_ACK_LATENCY(2),
    .FEATURE_CFG_CHECK("NONE")
  ) u_dut_nc (
    .clk(clk), .rst_n(rst_n),
    .spr_vr(cfg[0]), .spr_vr2(cfg[9]), .spr_upr(cfg[1]), .spr_cpucfgr(cfg[2]),
    .spr_dmmucfgr(cfg[3]), .spr_immucfgr(cfg[4]), .spr_dccfgr(cfg[5]),
    .spr_iccfgr(cfg[6]), .spr_dcfgr(cfg[7]), .spr_pccfgr(cfg[8]), .spr_avr(cfg[10]),
    .spr_bus_addr_i(spr_bus_addr_i), .spr_bus_stb_i(spr_bus_stb_i),
    .spr_bus_we_i(spr_bus_we_i), .spr_bus_dat_i(spr_bus_dat_i),
    .spr_bus_dat_o(dat_o[4]), .spr_bus_ack_o(ack_o[4]),
    .ro_wr_err_o(err_o[4]), .ro_wr_cnt_o(cnt_o[4]),
    .cfg_mismatch_o(mm_o[4]), .cfg_clear_i(cfg_clear_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s err[%0d]", tag, d), {31'd0, err_o[d]}, {31'd0, m_err});
      check($sformatf("%s cnt[%0d]", tag, d), {24'd0, cnt_o[d]}, {24'd0, m_cnt});
      check($sformatf("%s mm[%0d]", tag, d), {31'd0, mm_o[d]}, {31'd0, m_mm[d]});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("%s ack[%0d]", tag, d), {31'd0, ack_o[d]}, 32'd0);
      check($sformatf("%s dat[%0d]", tag, d), dat_o[d], 32'd0);
    end
    check_flags(tag);
  endtask

  // One access: stb held HOLDC cycles, then two idle cycles; ack timing, data and flags checked.
  task automatic run_txn(input logic [15:0] addr, input logic we);
    int          first [NDUT];
    int          nack  [NDUT];
    int          stray [NDUT];
    logic [31:0] got   [NDUT];
    logic [31:0] exp_d;
    bit          grp0, hit;
    grp0  = (addr[15:11] == 5'd0);
    hit   = grp0 && (addr[10:0] <= 11'd10);
    exp_d = (hit && !we) ? cfg[addr[3:0]] : 32'd0;
    for (int d = 0; d < NDUT; d++) begin
      first[d] = -1; nack[d] = 0; stray[d] = 0; got[d] = 32'd0;
    end
    @(negedge clk);
    spr_bus_addr_i = addr;
    spr_bus_we_i   = we;
    spr_bus_dat_i  = $urandom;
    spr_bus_stb_i  = 1'b1;
    for (int c = 1; c <= HOLDC + 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
        if (ack_o[d]) begin
          nack[d]++;
          if (first[d] < 0) begin
            first[d] = c;
            got[d]   = dat_o[d];
          end
        end else if (dat_o[d] != 32'd0) begin
          stray[d]++;
        end
      end
      if (c == HOLDC) spr_bus_stb_i = 1'b0;
    end
    if (hit && we) begin
      m_err = 1'b1;
      if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    end
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("nack[%0d] a=%h", d, addr), nack[d], grp0 ? 32'd1 : 32'd0);
      if (grp0) begin
        check($sformatf("lat[%0d] a=%h", d, addr), first[d], lat_exp[d]);
        check($sformatf("dat[%0d] a=%h we=%0b", d, addr, we), got[d], exp_d);
      end
      check($sformatf("stray[%0d]", d), stray[d], 32'd0);
    end
    check_flags("txn");
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    cfg_clear_i = 1'b1;
    @(negedge clk);
    cfg_clear_i = 1'b0;
    m_err = 1'b0;
    m_cnt = 8'd0;
    for (int d = 0; d < NDUT; d++) m_mm[d] = 1'b0;
    check_flags("clear");
  endtask

  task automatic model_reset();
    m_err = 1'b0;
    m_cnt = 8'd0;
    for (int d = 0; d < NDUT; d++) m_mm[d] = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    int          early [NDUT];
    for (int k = 0; k < 11; k++) cfg[k] = $urandom;
    cfg[2] = 32'h0000_0620;
    model_reset();

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed reads: index 2 (cpucfgr), index 9, group 1, group 0 index 15.
    run_txn(16'h0002, 1'b0);
    run_txn(16'h0009, 1'b0);
    run_txn(16'h0800, 1'b0);
    run_txn(16'h000F, 1'b0);
    run_txn(16'h000F, 1'b1);
    run_txn(16'h000A, 1'b0);
    run_txn(16'h0000, 1'b0);

    // Randomized accesses across groups, indices and directions.
    for (int t = 0; t < 40; t++) begin
      a[15:11] = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      a[10:0]  = ($urandom_range(0, 7) == 0) ? 11'($urandom_range(16, 2047))
                                             : 11'($urandom_range(0, 15));
      run_txn(a, ($urandom_range(0, 2) == 0));
    end
    pulse_clear();

    // Counter saturation.
    for (int t = 0; t < 300; t++) run_txn(16'h0001, 1'b1);
    check("sat cnt", {24'd0, cnt_o[0]}, 32'd255);
    pulse_clear();

    // Single-cycle corruption of dccfgr bit 5.
    @(negedge clk);
    cfg[5][5] = ~cfg[5][5];
    @(negedge clk);
    cfg[5][5] = ~cfg[5][5];
    for (int d = 0; d < NDUT; d++) m_mm[d] = check_en[d];
    check_flags("corrupt");
    repeat (5) @(negedge clk);
    check_flags("corrupt sticky");
    run_txn(16'h0005, 1'b0);
    pulse_clear();

    // Reset during the wait phase of the latency-4 instance.
    run_txn(16'h0003, 1'b1);
    for (int d = 0; d < NDUT; d++) early[d] = 0;
    @(negedge clk);
    spr_bus_addr_i = 16'h0004;
    spr_bus_we_i   = 1'b0;
    spr_bus_stb_i  = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ack_o[d]) early[d]++;
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async reset");
    spr_bus_stb_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ack_o[d]) early[d]++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) if (ack_o[d]) early[d]++;
    end
    for (int d = 0; d < NDUT; d++)
      check($sformatf("reset acks[%0d]", d), early[d], (lat_exp[d] <= 2) ? 32'd1 : 32'd0);

    // Access straight after the single INIT cycle.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(16'h0004, 1'b0);
    run_txn(16'h0002, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mor1kx_cfgrs_spr_port.md
Name: mor1kx_cfgrs_spr_port

Overview:
- SPR-bus slave for the group-0 read-only configuration registers VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2 and AVR.
- Sits downstream of the configuration-register generator: takes its eleven 32-bit constant outputs, serves them to the SPR bus with a fixed, parameterised ack latency, and flags write attempts.
- Supports functional safety: captures a signature of the configuration words after reset and continuously checks them for corruption.

Parameters:
- OPTION_SPR_ACK_LATENCY, 1: cycles from accepted strobe to ack; legal values 1..4; any other value behaves as 1.
- FEATURE_CFG_CHECK, "ENABLED": "NONE" removes the signature logic; cfg_mismatch_o is then tied to 0.

Ports:
- clk  in  1  core clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- spr_vr, spr_vr2, spr_upr, spr_cpucfgr, spr_dmmucfgr, spr_immucfgr, spr_dccfgr, spr_iccfgr, spr_dcfgr, spr_pccfgr, spr_avr  in  32 each  configuration words
- spr_bus_addr_i  in  16  SPR address, [15:11] group, [10:0] index
- spr_bus_stb_i  in  1  access strobe, held until ack
- spr_bus_we_i  in  1  write enable
- spr_bus_dat_i  in  32  write data, ignored
- spr_bus_dat_o  out  32  read data, valid while ack is high
- spr_bus_ack_o  out  1  access acknowledge, one-cycle pulse
- ro_wr_err_o  out  1  sticky: write to a group-0 config index seen
- ro_wr_cnt_o  out  8  saturating count of such writes
- cfg_mismatch_o  out  1  sticky: signature check failed
- cfg_clear_i  in  1  synchronous clear of sticky flags and counter

Behaviour:
- Reset (asynchronous assert, synchronous release): spr_bus_dat_o=0, spr_bus_ack_o=0, ro_wr_err_o=0, ro_wr_cnt_o=0, cfg_mismatch_o=0, signature=0, state=INIT, latency counter=0.
- Address decode: hit = (addr[15:11]==0) && (addr[10:0] <= 10).
  - Index map: 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR.
  - Group 0 with index >10: still acked, read data 0, no error.
  - Non-zero group: ignored, no ack, state unchanged.
- State machine INIT -> IDLE -> WAIT -> ACK -> HOLD -> IDLE:
  - INIT: one cycle after reset release. Captures the signature, goes to IDLE. A strobe during INIT is not accepted.
  - IDLE: on stb && group==0, latch the read word (write: latch 0) and go to WAIT with counter = OPTION_SPR_ACK_LATENCY-1. If the counter is 0, go straight to ACK.
  - WAIT: decrement the counter; go to ACK when it reaches 0.
  - ACK: ack=1 and dat_o=latched word for exactly one cycle, then HOLD.
  - HOLD: wait for stb=0, then IDLE. Back-to-back strobes therefore need at least one stb-low cycle.
  - Net effect: the strobe is sampled in cycle 0 and ack is high in cycle OPTION_SPR_ACK_LATENCY.
- dat_o returns to 0 in every cycle ack is low.
- Write to a group-0 decoded index (0..10), i.e. stb && we:
  - still acked with data 0;
  - ro_wr_err_o set in the ack cycle;
  - ro_wr_cnt_o incremented in the ack cycle, saturating at 255.
- cfg_clear_i clears ro_wr_err_o, ro_wr_cnt_o and cfg_mismatch_o next cycle. If it coincides with a set or increment event, the clear wins. It does not affect the bus FSM or the signature.
- Signature = XOR over k=0..10 of (word_k rotated left by k), words taken in index order.
  - Captured in INIT.
  - From IDLE onward it is recomputed combinationally every cycle; any inequality with the stored value sets cfg_mismatch_o on the next edge (sticky).
- Reset asserted mid-transaction: no ack is issued, the FSM returns to INIT and all outputs go to reset values immediately.

Test Plan:
- Latency 1, read index 2 with spr_cpucfgr=32'h0000_0620 -> ack exactly 1 cycle after stb, dat_o=32'h0000_0620; dat_o=0 and ack=0 on the next cycle.
- Latency 3, read index 9 -> ack in cycle 3 only; stb held after ack produces no second ack until stb drops and is re-asserted.
- Write to index 1, 300 times -> each write acked with data 0; ro_wr_err_o=1; ro_wr_cnt_o saturates at 255; cfg_clear_i -> both 0.
- Address 16'h0800 (group 1) -> no ack for 10 cycles. Address 16'h000F -> ack with data 0, no error flag.
- After INIT, flip bit 5 of spr_dccfgr for one cycle -> cfg_mismatch_o=1 next edge and stays 1 after restoring the input. With FEATURE_CFG_CHECK="NONE" it stays 0.
- Assert rst_n low in the WAIT state (latency 4) -> ack never pulses; after release, INIT takes 1 cycle, then a new read completes normally.
